pac_motion: RTL and testbench

- Producer side of the Pac-Man position/motion interface that the ghost chase blocks consume.
- Turns keyboard keycodes and per-frame wall-sense flags into Pac-Man's registered position, signed per-frame step and facing direction.
- Includes a buffered-turn state machine and stop/freeze handling.
- Sits between the USB keycode path and the ghosts, the collision logic and the sprite renderer; advances once per frame_clk.

---
 rtl/pac_pkg.sv | 46 ++++
 rtl/pac_turn_buffer.sv | 63 ++++++
 rtl/pac_motion.sv | 147 ++++++++++++++
 tb/tb_pac_motion.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pac_pkg.sv
// Shared types and constants for the Pac-Man motion block.
// Direction encoding matches the ghost direction-selection logic.
package pac_pkg;

   typedef enum logic [1:0] {
      DIR_L = 2'b00,
      DIR_R = 2'b01,
      DIR_U = 2'b10,
      DIR_D = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      StIdle,
      StMoving,
      StBlocked,
      StFrozen
   } pac_state_t;

   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_D = 8'h07;
   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_S = 8'h16;

   localparam int unsigned PAC_SIZE = 8;

   typedef struct packed {
      logic valid;
      dir_t dir;
   } key_req_t;

   // Map a USB keycode onto a direction request; unknown codes are no request.
   function automatic key_req_t decode_key(input logic [7:0] key);
      key_req_t req;
      req.valid = 1'b1;
      req.dir   = DIR_L;
      case (key)
         KEY_A:   req.dir = DIR_L;
         KEY_D:   req.dir = DIR_R;
         KEY_W:   req.dir = DIR_U;
         KEY_S:   req.dir = DIR_D;
         default: req.valid = 1'b0;
      endcase
      return req;
   endfunction

endpackage

// File: rtl/pac_turn_buffer.sv
// Buffered-turn request: decodes the keycode, remembers the last request and
// drops it after TURN_HOLD frames without a key. The outputs present the newest
// request, so a key pressed this frame can be acted on at this edge.
module pac_turn_buffer
   import pac_pkg::*;
#(
   parameter int unsigned TURN_HOLD = 8
) (
   input  logic       frame_clk,
   input  logic       Reset_n,
   input  logic [7:0] keycode,
   input  logic       clear,
   output logic       pend_valid,
   output dir_t       pend_dir
);

   localparam int unsigned HoldW = $clog2(TURN_HOLD + 1);
   localparam logic [HoldW-1:0] HoldInit = HoldW'(TURN_HOLD);
   localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

   key_req_t         req;
   logic             valid_q, valid_d;
   dir_t             dir_q, dir_d;
   logic [HoldW-1:0] hold_q, hold_d;

   assign req        = decode_key(keycode);
   assign pend_valid = req.valid | valid_q;
   assign pend_dir   = req.valid ? req.dir : dir_q;

   // Next pending state: clear beats a new key, a key reloads the hold time.
   always_comb begin
      valid_d = valid_q;
      dir_d   = dir_q;
      hold_d  = hold_q;
      if (clear) begin
         valid_d = 1'b0;
         hold_d  = '0;
      end else if (req.valid) begin
         valid_d = 1'b1;
         dir_d   = req.dir;
         hold_d  = HoldInit;
      end else if (hold_q != '0) begin
         hold_d = hold_q - HoldOne;
         if (hold_q == HoldOne) begin
            valid_d = 1'b0;
         end
      end
   end

   // Pending request registers.
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         valid_q <= 1'b0;
         dir_q   <= DIR_L;
         hold_q  <= '0;
      end else begin
         valid_q <= valid_d;
         dir_q   <= dir_d;
         hold_q  <= hold_d;
      end
   end

endmodule

// File: rtl/pac_motion.sv
// Pac-Man position/motion producer: keycodes plus per-frame wall flags become a
// registered position, signed per-frame step and facing direction.
// Optional build macro PAC_TUNNEL_WRAP_EN: X wraps between X_MIN and X_MAX
// instead of clamping and blocking at the bounds.
module pac_motion
   import pac_pkg::*;
#(
   parameter int unsigned START_X   = 320,
   parameter int unsigned START_Y   = 364,
   parameter int unsigned STEP      = 2,
   parameter int unsigned TURN_HOLD = 8,
   parameter int unsigned X_MIN     = 8,
   parameter int unsigned X_MAX     = 631
) (
   input  logic       frame_clk,
   input  logic       Reset_n,
   input  logic [7:0] keycode,
   input  logic       stop,
   input  logic       wall_l,
   input  logic       wall_r,
   input  logic       wall_u,
   input  logic       wall_d,
   output logic [9:0] pacX,
   output logic [9:0] pacY,
   output logic [9:0] pac_X_Motion,
   output logic [9:0] pac_Y_Motion,
   output logic [9:0] pacS,
   output dir_t       pac_dir,
   output logic       moving
);

   localparam logic [9:0] StepPos  = 10'(STEP);
   localparam logic [9:0] StepNeg  = ~StepPos + 10'd1;
   localparam logic [9:0] XMin     = 10'(X_MIN);
   localparam logic [9:0] XMax     = 10'(X_MAX);
   localparam logic [9:0] XLoLimit = XMin + StepPos;
   localparam logic [9:0] XHiLimit = XMax - StepPos;

   pac_state_t state_q, state_d;
   dir_t       dir_q, dir_d;
   logic [9:0] x_q, x_d, y_q, y_d;
   logic [9:0] xm_q, xm_d, ym_q, ym_d;
   logic [3:0] wall_vec;
   logic       pend_valid;
   dir_t       pend_dir;
   logic       clear;
   logic       move;

   // Indexed by dir_t.
   assign wall_vec = {wall_d, wall_u, wall_r, wall_l};

   pac_turn_buffer #(
      .TURN_HOLD (TURN_HOLD)
   ) u_turn_buffer (
      .frame_clk  (frame_clk),
      .Reset_n    (Reset_n),
      .keycode    (keycode),
      .clear      (clear),
      .pend_valid (pend_valid),
      .pend_dir   (pend_dir)
   );

   // Prioritised state/direction selection, then the step and X bound handling.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      xm_d    = '0;
      ym_d    = '0;
      clear   = 1'b0;
      move    = 1'b0;

      if (stop) begin
         state_d = StFrozen;
         clear   = 1'b1;
      end else if (state_q == StFrozen) begin
         state_d = StIdle;
      end else if (pend_valid && !wall_vec[pend_dir]) begin
         dir_d   = pend_dir;
         clear   = 1'b1;
         state_d = StMoving;
         move    = 1'b1;
      end else if ((state_q == StMoving || state_q == StBlocked) && !wall_vec[dir_q]) begin
         state_d = StMoving;
         move    = 1'b1;
      end else if (state_q != StIdle) begin
         state_d = StBlocked;
      end

      if (move) begin
         unique case (dir_d)
            DIR_L: xm_d = StepNeg;
            DIR_R: xm_d = StepPos;
            DIR_U: ym_d = StepNeg;
            DIR_D: ym_d = StepPos;
         endcase
      end

      x_d = x_q + xm_d;
      y_d = y_q + ym_d;

      if (move && dir_d == DIR_L && x_q < XLoLimit) begin
`ifdef PAC_TUNNEL_WRAP_EN
         x_d = XMax;
`else
         x_d     = XMin;
         xm_d    = '0;
         state_d = StBlocked;
`endif
      end else if (move && dir_d == DIR_R && x_q > XHiLimit) begin
`ifdef PAC_TUNNEL_WRAP_EN
         x_d = XMin;
`else
         x_d     = XMax;
         xm_d    = '0;
         state_d = StBlocked;
`endif
      end
   end

   // Frame-rate state, position and motion registers.
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= StIdle;
         dir_q   <= DIR_L;
         x_q     <= 10'(START_X);
         y_q     <= 10'(START_Y);
         xm_q    <= '0;
         ym_q    <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         x_q     <= x_d;
         y_q     <= y_d;
         xm_q    <= xm_d;
         ym_q    <= ym_d;
      end
   end

   assign pacX         = x_q;
   assign pacY         = y_q;
   assign pac_X_Motion = xm_q;
   assign pac_Y_Motion = ym_q;
   assign pacS         = 10'(PAC_SIZE);
   assign pac_dir      = dir_q;
   assign moving       = (state_q == StMoving);

endmodule

// File: tb/tb_pac_motion.sv
// Self-checking bench for pac_motion: a table of per-frame vectors plus short
// hand sequences for asynchronous reset and the X bound (clamp or tunnel wrap).
module tb_pac_motion;

   localparam logic [1:0] DL = 2'd0;
   localparam logic [1:0] DR = 2'd1;
   localparam logic [1:0] DU = 2'd2;
   localparam logic [1:0] DD = 2'd3;
   localparam logic [9:0] NEG2 = 10'h3FE;

   typedef struct {
      logic [7:0] key;
      logic       stop;
      logic [3:0] walls;   // {d, u, r, l}
      logic [9:0] x;
      logic [9:0] y;
      logic [9:0] xm;
      logic [9:0] ym;
      logic [1:0] dir;
      logic       mv;
   } vec_t;

   logic       frame_clk = 1'b0;
   logic       Reset_n, e_rst_n;
   logic [7:0] keycode, e_key;
   logic       stop, e_stop;
   logic [3:0] walls, e_walls;
   logic [9:0] pacX, pacY, xm, ym, pacS;
   logic [9:0] e_x, e_y, e_xm, e_ym, e_s;
   logic [1:0] pac_dir, e_dir;
   logic       moving, e_mv;

   int n_cmp = 0;
   int n_err = 0;

   vec_t tbl[$];
   vec_t exp_q[$];

   always #5 frame_clk = ~frame_clk;

   pac_motion dut (
      .frame_clk    (frame_clk),
      .Reset_n      (Reset_n),
      .keycode      (keycode),
      .stop         (stop),
      .wall_l       (walls[0]),
      .wall_r       (walls[1]),
      .wall_u       (walls[2]),
      .wall_d       (walls[3]),
      .pacX         (pacX),
      .pacY         (pacY),
      .pac_X_Motion (xm),
      .pac_Y_Motion (ym),
      .pacS         (pacS),
      .pac_dir      (pac_dir),
      .moving       (moving)
   );

   // Second instance starting at an odd X next to the left bound.
   pac_motion #(
      .START_X (9)
   ) dut_edge (
      .frame_clk    (frame_clk),
      .Reset_n      (e_rst_n),
      .keycode      (e_key),
      .stop         (e_stop),
      .wall_l       (e_walls[0]),
      .wall_r       (e_walls[1]),
      .wall_u       (e_walls[2]),
      .wall_d       (e_walls[3]),
      .pacX         (e_x),
      .pacY         (e_y),
      .pac_X_Motion (e_xm),
      .pac_Y_Motion (e_ym),
      .pacS         (e_s),
      .pac_dir      (e_dir),
      .moving       (e_mv)
   );

   function automatic vec_t mk(input logic [7:0] key, input logic stp, input logic [3:0] w,
                               input logic [9:0] x, input logic [9:0] y, input logic [9:0] xmo,
                               input logic [9:0] ymo, input logic [1:0] d, input logic mv);
      vec_t v;
      v.key = key; v.stop = stp; v.walls = w;
      v.x = x; v.y = y; v.xm = xmo; v.ym = ymo; v.dir = d; v.mv = mv;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic cmp_all(input string name, input vec_t e, input bit sel);
      cmp({name, ".x"},   sel ? e_x  : pacX,    e.x);
      cmp({name, ".y"},   sel ? e_y  : pacY,    e.y);
      cmp({name, ".xm"},  sel ? e_xm : xm,      e.xm);
      cmp({name, ".ym"},  sel ? e_ym : ym,      e.ym);
      cmp({name, ".dir"}, 10'(sel ? e_dir : pac_dir), 10'(e.dir));
      cmp({name, ".mv"},  10'(sel ? e_mv : moving),   10'(e.mv));
   endtask

   // Drive one frame of stimulus, queue its expectation, check after the edge.
   task automatic run_row(input string name, input vec_t v, input bit sel);
      vec_t e;
      if (sel) begin
         e_key = v.key; e_stop = v.stop; e_walls = v.walls;
      end else begin
         keycode = v.key; stop = v.stop; walls = v.walls;
      end
      exp_q.push_back(v);
      @(posedge frame_clk);
      #1;
      e = exp_q.pop_front();
      cmp_all(name, e, sel);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      Reset_n = 1'b0; keycode = '0; stop = 1'b0; walls = '0;
      e_rst_n = 1'b0; e_key = '0; e_stop = 1'b0; e_walls = '0;

      // Idle, then right, turn taken after 3 frames, turn discarded after 9 frames.
      for (int i = 0; i < 10; i++) tbl.push_back(mk(8'h00, 0, 4'b0000, 320, 364, 0, 0, DL, 0));
      tbl.push_back(mk(8'h07, 0, 4'b0000, 322, 364, 2, 0, DR, 1));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(8'h00, 0, 4'b0000, 10'(324 + 2 * i), 364, 2, 0,
                                                   DR, 1));
      tbl.push_back(mk(8'h1A, 0, 4'b0100, 332, 364, 2, 0, DR, 1));
      tbl.push_back(mk(8'h00, 0, 4'b0100, 334, 364, 2, 0, DR, 1));
      tbl.push_back(mk(8'h00, 0, 4'b0100, 336, 364, 2, 0, DR, 1));
      tbl.push_back(mk(8'h00, 0, 4'b0000, 336, 362, 0, NEG2, DU, 1));
      tbl.push_back(mk(8'h07, 0, 4'b0000, 338, 362, 2, 0, DR, 1));
      tbl.push_back(mk(8'h1A, 0, 4'b0100, 340, 362, 2, 0, DR, 1));
      for (int i = 0; i < 8; i++) tbl.push_back(mk(8'h00, 0, 4'b0100, 10'(342 + 2 * i), 362, 2, 0,
                                                   DR, 1));
      tbl.push_back(mk(8'h00, 0, 4'b0000, 358, 362, 2, 0, DR, 1));
      // Wall ahead blocks on the same edge, clearing it resumes without a key.
      tbl.push_back(mk(8'h00, 0, 4'b0010, 358, 362, 0, 0, DR, 0));
      tbl.push_back(mk(8'h00, 0, 4'b0010, 358, 362, 0, 0, DR, 0));
      tbl.push_back(mk(8'h00, 0, 4'b0000, 360, 362, 2, 0, DR, 1));
      // Stop beats a key, then idle with the request forgotten.
      tbl.push_back(mk(8'h04, 1, 4'b0000, 360, 362, 0, 0, DR, 0));
      tbl.push_back(mk(8'h00, 1, 4'b0000, 360, 362, 0, 0, DR, 0));
      tbl.push_back(mk(8'h00, 0, 4'b0000, 360, 362, 0, 0, DR, 0));
      tbl.push_back(mk(8'h00, 0, 4'b0000, 360, 362, 0, 0, DR, 0));
      // Left, immediate reversal, down, then a wall below.
      tbl.push_back(mk(8'h04, 0, 4'b0000, 358, 362, NEG2, 0, DL, 1));
      tbl.push_back(mk(8'h07, 0, 4'b0000, 360, 362, 2, 0, DR, 1));
      tbl.push_back(mk(8'h16, 0, 4'b0000, 360, 364, 0, 2, DD, 1));
      tbl.push_back(mk(8'h00, 0, 4'b1000, 360, 364, 0, 0, DD, 0));

      repeat (2) @(posedge frame_clk);
      #1;
      cmp_all("reset", mk(8'h00, 0, 4'b0000, 320, 364, 0, 0, DL, 0), 1'b0);
      cmp("reset.pacS", pacS, 10'd8);
      Reset_n = 1'b1;

      foreach (tbl[i]) run_row($sformatf("row%0d", i), tbl[i], 1'b0);

      // Asynchronous reset in the middle of a move.
      run_row("premove", mk(8'h07, 0, 4'b0000, 362, 364, 2, 0, DR, 1), 1'b0);
      #3;
      Reset_n = 1'b0;
      #1;
      cmp_all("async_rst", mk(8'h00, 0, 4'b0000, 320, 364, 0, 0, DL, 0), 1'b0);
      keycode = 8'h00;
      @(posedge frame_clk);
      #1;
      Reset_n = 1'b1;
      run_row("post_rst", mk(8'h00, 0, 4'b0000, 320, 364, 0, 0, DL, 0), 1'b0);

      // Left bound from X=9.
      e_rst_n = 1'b1;
      cmp("edge.pacS", e_s, 10'd8);
`ifdef PAC_TUNNEL_WRAP_EN
      run_row("wrap0", mk(8'h04, 0, 4'b0000, 631, 364, NEG2, 0, DL, 1), 1'b1);
      run_row("wrap1", mk(8'h00, 0, 4'b0000, 629, 364, NEG2, 0, DL, 1), 1'b1);
`else
      run_row("clamp0", mk(8'h04, 0, 4'b0000, 8, 364, 0, 0, DL, 0), 1'b1);
      run_row("clamp1", mk(8'h00, 0, 4'b0000, 8, 364, 0, 0, DL, 0), 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
